// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: shares one SPI shift engine between NREQ requesters.
// Ownership is granted round-robin. Each owner gets its own active-low chip
// select with setup, hold and inter-owner gap timing. Multi-word bursts keep
// the select low between words. A watchdog aborts a transfer, with an error
// pulse, when the engine hangs or a locked owner stops requesting.
module spi_xfer_sched #(
    parameter int NREQ     = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_word,
    input  logic [2*NREQ-1:0]    req_bits,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rx_word,
    output logic                 err,
    output logic [NREQ-1:0]      cs_n,
    output logic                 eng_start,
    output logic [31:0]          eng_tx,
    output logic [1:0]           eng_bits,
    input  logic                 eng_done,
    input  logic [31:0]          eng_rx
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = 16;

    // Terminal counts: every timed state starts its counter at zero.
    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] TO_END    = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_DONE,
        S_LOCKED,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic            last_q;

    logic [IW-1:0]   pick;
    logic [31:0]     own_word;
    logic [1:0]      own_bits;
    logic            own_last;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Round-robin pick: first requesting index at or above rr_ptr, wrapping.
    // The index sum wraps by itself because NREQ is a power of two.
    always_comb begin
        pick = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rr_ptr + IW'(k)]) begin
                pick = rr_ptr + IW'(k);
            end
        end
    end

    // Transaction fields of the current owner, sampled when entering START.
    always_comb begin
        own_word = req_word[owner*32 +: 32];
        own_bits = req_bits[owner*2 +: 2];
        own_last = req_last[owner];
    end

    // Scheduler FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            last_q    <= 1'b0;
            gnt       <= '0;
            cs_n      <= '1;
            done      <= '0;
            err       <= 1'b0;
            rx_word   <= '0;
            eng_start <= 1'b0;
            eng_tx    <= '0;
            eng_bits  <= '0;
        end else begin
            done      <= '0;
            err       <= 1'b0;
            eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        owner <= pick;
                        gnt   <= onehot(pick);
                        cs_n  <= ~onehot(pick);
                        cnt   <= '0;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_END) begin
                        eng_start <= 1'b1;
                        eng_tx    <= own_word;
                        eng_bits  <= own_bits;
                        last_q    <= own_last;
                        state     <= S_START;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        rx_word <= eng_rx;
                        done    <= onehot(owner);
                        state   <= S_DONE;
                    end else if (cnt == TO_END) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    cnt   <= '0;
                    state <= last_q ? S_HOLD : S_LOCKED;
                end
                S_LOCKED: begin
                    // Bus stays owned; only the owner's request matters here.
                    if (req[owner]) begin
                        eng_start <= 1'b1;
                        eng_tx    <= own_word;
                        eng_bits  <= own_bits;
                        last_q    <= own_last;
                        state     <= S_START;
                    end else if (cnt == TO_END) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_END) begin
                        cs_n   <= '1;
                        gnt    <= '0;
                        rr_ptr <= owner + IW'(1);
                        cnt    <= '0;
                        state  <= S_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_END) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: queue-driven requesters, a latency-programmable
// engine stand-in, and a transaction-level model of chip-select ownership
// (owner order, select-low duration, done/err counts).
module tb_spi_xfer_sched;
    localparam int NREQ  = 4;
    localparam int SETUP = 3;
    localparam int HOLD  = 2;
    localparam int GAP   = 2;
    localparam int TO    = 24;
    localparam int QD    = 32;
    localparam int SMAX  = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   req_word;
    logic [2*NREQ-1:0]    req_bits;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [31:0]          rx_word;
    logic                 err;
    logic [NREQ-1:0]      cs_n;
    logic                 eng_start;
    logic [31:0]          eng_tx;
    logic [1:0]           eng_bits;
    logic                 eng_done;
    logic [31:0]          eng_rx;

    always #5 clk = ~clk;

    spi_xfer_sched #(
        .NREQ(NREQ), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_GAP(GAP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_word(req_word), .req_bits(req_bits),
        .req_last(req_last), .gnt(gnt), .done(done), .rx_word(rx_word), .err(err),
        .cs_n(cs_n), .eng_start(eng_start), .eng_tx(eng_tx), .eng_bits(eng_bits),
        .eng_done(eng_done), .eng_rx(eng_rx)
    );

    int checks = 0;
    int failures = 0;

    // Requester queues (word, length code, last flag, engine latency; 0 = hang)
    logic [31:0] mem_w   [NREQ][QD];
    logic [1:0]  mem_b   [NREQ][QD];
    logic        mem_l   [NREQ][QD];
    int          mem_lat [NREQ][QD];
    int          hd [NREQ];
    int          tl [NREQ];

    int          eng_cnt;
    logic [31:0] exp_rx;
    int          cyc, last_start_cyc, err_delay;
    int          m_rr;
    logic [NREQ-1:0] prev_gnt;

    // Ownership segment monitor
    int low_len, hi_len, cur_own, cur_gap, cur_done, cur_err, cur_starts, cur_lat;
    int seg_n;
    int seg_own [SMAX];
    int seg_len [SMAX];
    int seg_done [SMAX];
    int seg_err [SMAX];
    int seg_gap [SMAX];
    int seg_starts [SMAX];
    int seg_lat [SMAX];

    function automatic int idx_of(input logic [NREQ-1:0] v);
        idx_of = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) idx_of = i;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        rr_pick = -1;
        for (int k = 0; k < NREQ; k++)
            if (rr_pick < 0 && r[(p + k) % NREQ]) rr_pick = (p + k) % NREQ;
    endfunction

    // Select-low cycles of an ownership whose words all completed normally.
    function automatic int exp_len(input int starts, input int lat_sum);
        exp_len = SETUP + lat_sum + 2 * starts + (starts - 1) + HOLD;
    endfunction

    task automatic push(input int i, input logic [31:0] w, input logic [1:0] b,
                        input logic l, input int lat);
        if (hd[i] == tl[i]) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        if (tl[i] < QD) begin
            mem_w[i][tl[i]]   = w;
            mem_b[i][tl[i]]   = b;
            mem_l[i][tl[i]]   = l;
            mem_lat[i][tl[i]] = lat;
            tl[i]++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (hd[i] < tl[i]);
            if (hd[i] < tl[i]) begin
                req_word[i*32 +: 32] = mem_w[i][hd[i]];
                req_bits[i*2 +: 2]   = mem_b[i][hd[i]];
                req_last[i]          = mem_l[i][hd[i]];
            end
        end
    endtask

    // One clock: observe outputs, run engine/requester models, redrive inputs.
    task automatic step();
        int own;
        int exp_own;
        @(posedge clk);
        #1;
        cyc++;
        own = idx_of(gnt);
        checks++;
        if ($countones(~cs_n) > 1 || gnt !== ~cs_n) begin
            failures++;
            $display("FAIL cs_gnt_agree: cyc=%0d cs_n=%b gnt=%b, required <=1 low and gnt==~cs_n", cyc, cs_n, gnt);
        end
        if (!rst && prev_gnt == '0 && gnt != '0) begin
            exp_own = rr_pick(req, m_rr);
            checks++;
            if (own != exp_own) begin
                failures++;
                $display("FAIL arbitration: cyc=%0d got owner %0d, required %0d", cyc, own, exp_own);
            end
        end
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1;
                eng_rx   = $urandom;
                exp_rx   = eng_rx;
            end
        end
        if (eng_start) begin
            checks++;
            if (eng_cnt > 0 || own < 0 || hd[own] >= tl[own]) begin
                failures++;
                $display("FAIL eng_start_legal: cyc=%0d owner=%0d engine_busy=%0d", cyc, own, eng_cnt);
            end else begin
                checks++;
                if (eng_tx !== mem_w[own][hd[own]] || eng_bits !== mem_b[own][hd[own]]) begin
                    failures++;
                    $display("FAIL eng_tx: got %h/%0d, required %h/%0d", eng_tx, eng_bits,
                             mem_w[own][hd[own]], mem_b[own][hd[own]]);
                end
                eng_cnt = mem_lat[own][hd[own]];
                cur_starts++;
                cur_lat += eng_cnt;
                last_start_cyc = cyc;
            end
        end
        if (done != '0) begin
            checks++;
            if (done !== gnt || rx_word !== exp_rx) begin
                failures++;
                $display("FAIL done_rx: done=%b gnt=%b rx_word=%h, required done==gnt rx=%h", done, gnt, rx_word, exp_rx);
            end
            cur_done++;
            if (own >= 0 && hd[own] < tl[own]) hd[own]++;
        end
        if (err) begin
            cur_err++;
            err_delay = cyc - last_start_cyc;
            if (own >= 0 && hd[own] < tl[own]) hd[own]++;
        end
        if (cs_n != '1) begin
            if (low_len == 0) begin
                cur_own = own;
                cur_gap = hi_len;
            end
            low_len++;
            hi_len = 0;
        end else begin
            if (low_len > 0) begin
                if (seg_n < SMAX) begin
                    seg_own[seg_n]    = cur_own;
                    seg_len[seg_n]    = low_len;
                    seg_done[seg_n]   = cur_done;
                    seg_err[seg_n]    = cur_err;
                    seg_gap[seg_n]    = cur_gap;
                    seg_starts[seg_n] = cur_starts;
                    seg_lat[seg_n]    = cur_lat;
                end
                seg_n++;
                m_rr = (cur_own + 1) % NREQ;
                low_len = 0; cur_done = 0; cur_err = 0; cur_starts = 0; cur_lat = 0;
            end
            hi_len++;
        end
        prev_gnt = gnt;
        drive_inputs();
    endtask

    task automatic run_idle(input int budget, input string name);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            step();
            n++;
            busy = 1'b0;
            for (int i = 0; i < NREQ; i++) if (hd[i] < tl[i]) busy = 1'b1;
            if (cs_n != '1 || hi_len < GAP + 2 || eng_cnt != 0) busy = 1'b1;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s_drain: not idle after %0d cycles, cs_n=%b", name, budget, cs_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (cs_n !== '1 || gnt !== '0) begin
            failures++;
            $display("FAIL reset_cs_gnt: cs_n=%b gnt=%b, required 1111/0000", cs_n, gnt);
        end
        checks++;
        if (done !== '0 || err !== 1'b0 || eng_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: done=%b err=%b eng_start=%b, required 0", done, err, eng_start);
        end
        checks++;
        if (eng_tx !== 32'h0 || eng_bits !== 2'd0 || rx_word !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: eng_tx=%h eng_bits=%0d rx_word=%h, required 0", eng_tx, eng_bits, rx_word);
        end
        rst = 1'b0;
        m_rr = 0;
        seg_n = 0;
    endtask

    task automatic test_single_word();
        seg_n = 0;
        push(1, 32'hA5, 2'd0, 1'b1, 20);
        drive_inputs();
        run_idle(500, "single");
        checks++;
        if (seg_n != 1 || seg_own[0] != 1 || seg_len[0] != SETUP + 1 + 20 + 1 + HOLD) begin
            failures++;
            $display("FAIL single_cs: segs=%0d owner=%0d low=%0d, required 1/1/%0d", seg_n, seg_own[0], seg_len[0], SETUP + 22 + HOLD);
        end
        checks++;
        if (seg_done[0] != 1 || seg_err[0] != 0) begin
            failures++;
            $display("FAIL single_pulses: done=%0d err=%0d, required 1/0", seg_done[0], seg_err[0]);
        end
        checks++;
        if (eng_tx !== 32'hA5 || eng_bits !== 2'd0 || rx_word !== exp_rx) begin
            failures++;
            $display("FAIL single_data: eng_tx=%h bits=%0d rx=%h, required a5/0/%h", eng_tx, eng_bits, rx_word, exp_rx);
        end
    endtask

    task automatic test_round_robin();
        int base;
        seg_n = 0;
        base = m_rr;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                push(i, $urandom, 2'($urandom_range(0, 3)), 1'b1, int'($urandom_range(1, 6)));
        drive_inputs();
        run_idle(2000, "rr");
        checks++;
        if (seg_n != 2 * NREQ) begin
            failures++;
            $display("FAIL rr_count: got %0d owners, required %0d", seg_n, 2 * NREQ);
        end
        for (int k = 0; k < seg_n && k < 2 * NREQ; k++) begin
            checks++;
            if (seg_own[k] != (base + k) % NREQ || seg_len[k] != exp_len(1, seg_lat[k]) || seg_done[k] != 1) begin
                failures++;
                $display("FAIL rr_owner%0d: owner=%0d low=%0d done=%0d, required %0d/%0d/1", k, seg_own[k],
                         seg_len[k], seg_done[k], (base + k) % NREQ, exp_len(1, seg_lat[k]));
            end
            if (k > 0) begin
                checks++;
                if (seg_gap[k] != GAP + 1) begin
                    failures++;
                    $display("FAIL rr_gap%0d: got %0d all-high cycles, required %0d", k, seg_gap[k], GAP + 1);
                end
            end
        end
    endtask

    task automatic test_locked_burst();
        seg_n = 0;
        push(2, $urandom, 2'd3, 1'b0, 5);
        push(2, $urandom, 2'd1, 1'b0, 4);
        push(2, $urandom, 2'd2, 1'b1, 6);
        drive_inputs();
        step();
        push(0, $urandom, 2'd0, 1'b1, 3);
        drive_inputs();
        run_idle(1000, "burst");
        checks++;
        if (seg_n != 2 || seg_own[0] != 2 || seg_len[0] != SETUP + 21 + 2 + HOLD || seg_done[0] != 3) begin
            failures++;
            $display("FAIL burst_lock: segs=%0d owner=%0d low=%0d done=%0d, required 2/2/%0d/3", seg_n,
                     seg_own[0], seg_len[0], seg_done[0], SETUP + 23 + HOLD);
        end
        checks++;
        if (seg_own[1] != 0 || seg_gap[1] != GAP + 1 || seg_len[1] != SETUP + 5 + HOLD) begin
            failures++;
            $display("FAIL burst_next: owner=%0d gap=%0d low=%0d, required 0/%0d/%0d", seg_own[1], seg_gap[1],
                     seg_len[1], GAP + 1, SETUP + 5 + HOLD);
        end
    endtask

    task automatic test_timeout();
        seg_n = 0;
        push(3, $urandom, 2'd1, 1'b1, 0);
        drive_inputs();
        step();
        push(1, $urandom, 2'd2, 1'b1, 7);
        drive_inputs();
        run_idle(1000, "timeout");
        checks++;
        if (seg_n != 2 || seg_own[0] != 3 || seg_len[0] != SETUP + 1 + TO + HOLD) begin
            failures++;
            $display("FAIL timeout_cs: segs=%0d owner=%0d low=%0d, required 2/3/%0d", seg_n, seg_own[0], seg_len[0], SETUP + 1 + TO + HOLD);
        end
        checks++;
        if (seg_done[0] != 0 || seg_err[0] != 1 || seg_done[1] != 1 || seg_err[1] != 0) begin
            failures++;
            $display("FAIL timeout_pulses: done=%0d,%0d err=%0d,%0d, required 0,1 / 1,0", seg_done[0], seg_done[1], seg_err[0], seg_err[1]);
        end
        checks++;
        if (seg_own[1] != 1 || seg_len[1] != exp_len(1, 7) || seg_gap[1] != GAP + 1) begin
            failures++;
            $display("FAIL timeout_next: owner=%0d low=%0d gap=%0d, required 1/%0d/%0d", seg_own[1], seg_len[1], seg_gap[1], exp_len(1, 7), GAP + 1);
        end
    endtask

    task automatic test_lock_abandon();
        int ed;
        seg_n = 0;
        push(0, $urandom, 2'd3, 1'b0, 4);
        drive_inputs();
        run_idle(1000, "abandon");
        ed = err_delay;
        checks++;
        if (seg_n != 1 || seg_own[0] != 0 || seg_len[0] != SETUP + 1 + 4 + 1 + TO + HOLD) begin
            failures++;
            $display("FAIL abandon_cs: segs=%0d owner=%0d low=%0d, required 1/0/%0d", seg_n, seg_own[0], seg_len[0], SETUP + 6 + TO + HOLD);
        end
        checks++;
        if (seg_done[0] != 1 || seg_err[0] != 1 || ed != 4 + 2 + TO) begin
            failures++;
            $display("FAIL abandon_err: done=%0d err=%0d err_after_start=%0d, required 1/1/%0d", seg_done[0], seg_err[0], ed, 4 + 2 + TO);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        seg_n = 0;
        push(2, $urandom, 2'd1, 1'b1, 15);
        drive_inputs();
        n = 0;
        while (!eng_start && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (!eng_start) begin
            failures++;
            $display("FAIL rstwait_start: no eng_start within 50 cycles");
        end
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (cs_n !== '1 || gnt !== '0 || eng_start !== 1'b0 || done !== '0) begin
            failures++;
            $display("FAIL rstwait_outputs: cs_n=%b gnt=%b eng_start=%b done=%b, required 1111/0000/0/0000", cs_n, gnt, eng_start, done);
        end
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive_inputs();
        m_rr = 0;
        seg_n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (done !== '0 || gnt !== '0) begin
                failures++;
                $display("FAIL rstwait_stale: done=%b gnt=%b, required 0 after reset", done, gnt);
            end
        end
        push(3, $urandom, 2'd0, 1'b1, 5);
        push(0, $urandom, 2'd0, 1'b1, 5);
        drive_inputs();
        run_idle(1000, "rstwait");
        checks++;
        if (seg_n != 2 || seg_own[0] != 0 || seg_own[1] != 3) begin
            failures++;
            $display("FAIL rstwait_rr: segs=%0d owners=%0d,%0d, required 2 owners 0,3", seg_n, seg_own[0], seg_own[1]);
        end
    endtask

    task automatic test_random();
        int nw, words;
        for (int round = 0; round < 6; round++) begin
            seg_n = 0;
            words = 0;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    nw = int'($urandom_range(1, 3));
                    for (int w = 0; w < nw; w++)
                        push(i, $urandom, 2'($urandom_range(0, 3)), (w == nw - 1), int'($urandom_range(1, TO - 2)));
                    words += nw;
                end
            end
            drive_inputs();
            run_idle(3000, "random");
            for (int k = 0; k < seg_n && k < SMAX; k++) begin
                checks++;
                if (seg_starts[k] < 1 || seg_len[k] != exp_len(seg_starts[k], seg_lat[k]) ||
                    seg_done[k] != seg_starts[k] || seg_err[k] != 0 || seg_gap[k] < GAP + 1) begin
                    failures++;
                    $display("FAIL random_seg r%0d k%0d: owner=%0d low=%0d words=%0d done=%0d err=%0d gap=%0d, required low=%0d",
                             round, k, seg_own[k], seg_len[k], seg_starts[k], seg_done[k], seg_err[k], seg_gap[k],
                             exp_len(seg_starts[k], seg_lat[k]));
                end
                words -= seg_done[k];
            end
            checks++;
            if (words != 0) begin
                failures++;
                $display("FAIL random_words r%0d: %0d words without done", round, words);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_word = '0;
        req_bits = '0;
        req_last = '0;
        eng_done = 1'b0;
        eng_rx = '0;
        eng_cnt = 0;
        exp_rx = '0;
        cyc = 0;
        last_start_cyc = 0;
        err_delay = 0;
        m_rr = 0;
        prev_gnt = '0;
        low_len = 0; hi_len = 0; cur_own = 0; cur_gap = 0;
        cur_done = 0; cur_err = 0; cur_starts = 0; cur_lat = 0;
        seg_n = 0;
        for (int i = 0; i < NREQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        test_reset();
        test_single_word();
        test_round_robin();
        test_locked_burst();
        test_timeout();
        test_lock_abandon();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
